// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Counter width: must hold 0..width without wrapping.
   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width + 1);
   endfunction

   // Full-subtractor truth tables, indexed by {a, b, bin}.
   localparam logic [7:0] FS_D_TRUTH    = 8'h96;
   localparam logic [7:0] FS_BOUT_TRUTH = 8'h8E;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the serial subtractor.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             zero;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow, zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow, zero
   );
endinterface

// File: rtl/serial_subtractor_full_sub_stage.sv
// Single-bit full subtractor built from primitive gates.
module full_sub_stage (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic na;
   logic t_ab;
   logic t_abin;
   logic t_bbin;

   not g_na   (na, a);
   xor g_d    (d, a, b, bin);
   and g_ab   (t_ab, na, b);
   and g_abin (t_abin, na, bin);
   and g_bbin (t_bbin, b, bin);
   or  g_bout (bout, t_ab, t_abin, t_bbin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);
   localparam int unsigned CNT_W = cnt_w(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   ra;
   logic [WIDTH-1:0]   ra_nxt;
   logic [WIDTH-1:0]   rb;
   logic [WIDTH-1:0]   rb_nxt;
   logic [WIDTH-1:0]   result;
   logic [WIDTH-1:0]   result_nxt;
   logic [WIDTH-1:0]   result_shift;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               bin;
   logic               bin_nxt;
   logic               busy_ff;
   logic               busy_nxt;
   logic               done_ff;
   logic               done_nxt;
   logic [WIDTH-1:0]   diff_ff;
   logic [WIDTH-1:0]   diff_nxt;
   logic               borrow_ff;
   logic               borrow_nxt;
   logic               zero_ff;
   logic               zero_nxt;
   logic               stage_d;
   logic               stage_bout;

   full_sub_stage u_stage (
      .a    (ra[0]),
      .b    (rb[0]),
      .bin  (bin),
      .d    (stage_d),
      .bout (stage_bout)
   );

   // New difference bit enters at the MSB; a 1-bit result is just the bit.
   generate
      if (WIDTH == 1) begin : g_shift_w1
         assign result_shift = stage_d;
      end else begin : g_shift_wn
         assign result_shift = {stage_d, result[WIDTH-1:1]};
      end
   endgenerate

   // State and datapath registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ra        <= '0;
         rb        <= '0;
         result    <= '0;
         cnt       <= '0;
         bin       <= 1'b0;
         busy_ff   <= 1'b0;
         done_ff   <= 1'b0;
         diff_ff   <= '0;
         borrow_ff <= 1'b0;
         zero_ff   <= 1'b0;
      end else begin
         state     <= state_nxt;
         ra        <= ra_nxt;
         rb        <= rb_nxt;
         result    <= result_nxt;
         cnt       <= cnt_nxt;
         bin       <= bin_nxt;
         busy_ff   <= busy_nxt;
         done_ff   <= done_nxt;
         diff_ff   <= diff_nxt;
         borrow_ff <= borrow_nxt;
         zero_ff   <= zero_nxt;
      end
   end

   // Next-state and next-output logic; outputs are loaded on the last shift
   // so that done and the result appear together in the DONE cycle.
   always_comb begin
      state_nxt  = state;
      ra_nxt     = ra;
      rb_nxt     = rb;
      result_nxt = result;
      cnt_nxt    = cnt;
      bin_nxt    = bin;
      busy_nxt   = busy_ff;
      done_nxt   = 1'b0;
      diff_nxt   = diff_ff;
      borrow_nxt = borrow_ff;
      zero_nxt   = zero_ff;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = SHIFT;
               ra_nxt    = bus.a;
               rb_nxt    = bus.b;
               cnt_nxt   = '0;
               bin_nxt   = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         SHIFT: begin
            ra_nxt     = ra >> 1;
            rb_nxt     = rb >> 1;
            bin_nxt    = stage_bout;
            result_nxt = result_shift;
            cnt_nxt    = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_nxt  = DONE;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
               diff_nxt   = result_shift;
               borrow_nxt = stage_bout;
               zero_nxt   = (result_shift == '0);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.busy   = busy_ff;
   assign bus.done   = done_ff;
   assign bus.diff   = diff_ff;
   assign bus.borrow = borrow_ff;
   assign bus.zero   = zero_ff;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1).
module tb_serial_subtractor;
   import serial_sub_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   logic [7:0] last_diff;

   serial_subtractor_if #(.WIDTH(8)) if8 ();
   serial_subtractor_if #(.WIDTH(1)) if1 ();

   serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
   serial_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

   logic ta, tb_b, tc, td, tbo;
   full_sub_stage u_chk (.a(ta), .b(tb_b), .bin(tc), .d(td), .bout(tbo));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One WIDTH=8 op; optionally pulse a stray start at edge 'inj' after acceptance.
   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input int inj, input logic [7:0] ed, input logic eb, input logic ez);
      int done_cnt;
      int done_at;
      done_cnt = 0;
      done_at  = -1;
      @(posedge clk); #1;
      if8.start = 1'b1; if8.a = av; if8.b = bv;
      @(posedge clk); #1;
      if8.start = 1'b0; if8.a = 8'hAA; if8.b = 8'h55;
      check({tag, " busy_on"}, 32'(if8.busy), 32'd1);
      check({tag, " diff_held"}, 32'(if8.diff), 32'(last_diff));
      for (int k = 1; k <= 12; k++) begin
         if (k == inj) begin
            if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20;
         end else begin
            if8.start = 1'b0;
         end
         @(posedge clk); #1;
         if (k == 4) check({tag, " busy_mid"}, 32'(if8.busy), 32'd1);
         if (if8.done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = k;
               check({tag, " diff"}, 32'(if8.diff), 32'(ed));
               check({tag, " borrow"}, 32'(if8.borrow), 32'(eb));
               check({tag, " zero"}, 32'(if8.zero), 32'(ez));
               check({tag, " busy_done"}, 32'(if8.busy), 32'd0);
            end
         end
      end
      if8.start = 1'b0;
      check({tag, " latency"}, 32'(done_at), 32'd8);
      check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
      last_diff = ed;
   endtask

   // One WIDTH=1 op: done must be high one edge after acceptance.
   task automatic run_op1(input string tag, input logic av, input logic bv,
                          input logic ed, input logic eb, input logic ez);
      @(posedge clk); #1;
      if1.start = 1'b1; if1.a = av; if1.b = bv;
      @(posedge clk); #1;
      if1.start = 1'b0;
      check({tag, " busy"}, 32'(if1.busy), 32'd1);
      @(posedge clk); #1;
      check({tag, " done"}, 32'(if1.done), 32'd1);
      check({tag, " diff"}, 32'(if1.diff), 32'(ed));
      check({tag, " borrow"}, 32'(if1.borrow), 32'(eb));
      check({tag, " zero"}, 32'(if1.zero), 32'(ez));
      @(posedge clk); #1;
      check({tag, " done_low"}, 32'(if1.done), 32'd0);
   endtask

   initial begin
      logic [7:0] dtab;
      logic [7:0] btab;
      int         done_cnt;
      n_cmp = 0;
      n_bad = 0;
      last_diff = 8'h00;
      rst = 1'b1;
      if8.start = 1'b0; if8.a = '0; if8.b = '0;
      if1.start = 1'b0; if1.a = '0; if1.b = '0;
      ta = 1'b0; tb_b = 1'b0; tc = 1'b0;

      // Stage truth table
      dtab = FS_D_TRUTH;
      btab = FS_BOUT_TRUTH;
      for (int i = 0; i < 8; i++) begin
         {ta, tb_b, tc} = 3'(i);
         #1;
         check($sformatf("stage_d[%0d]", i), 32'(td), 32'(dtab[i]));
         check($sformatf("stage_bout[%0d]", i), 32'(tbo), 32'(btab[i]));
      end

      // Reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst busy", 32'(if8.busy), 32'd0);
      check("rst done", 32'(if8.done), 32'd0);
      check("rst diff", 32'(if8.diff), 32'd0);
      check("rst borrow", 32'(if8.borrow), 32'd0);
      check("rst zero", 32'(if8.zero), 32'd0);

      // Basic ops
      run_op("5-3", 8'h05, 8'h03, -1, 8'h02, 1'b0, 1'b0);
      run_op("3-5", 8'h03, 8'h05, -1, 8'hFE, 1'b1, 1'b0);
      run_op("0-1", 8'h00, 8'h01, -1, 8'hFF, 1'b1, 1'b0);
      run_op("7F-7F", 8'h7F, 8'h7F, -1, 8'h00, 1'b0, 1'b1);
      run_op("C8-37", 8'hC8, 8'h37, -1, 8'h91, 1'b0, 1'b0);

      // Stray start during SHIFT is ignored
      run_op("FF-1 inj", 8'hFF, 8'h01, 3, 8'hFE, 1'b0, 1'b0);

      // Reset mid-SHIFT aborts the op
      @(posedge clk); #1;
      if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h01;
      @(posedge clk); #1;
      if8.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort busy", 32'(if8.busy), 32'd0);
      check("abort done", 32'(if8.done), 32'd0);
      check("abort diff", 32'(if8.diff), 32'd0);
      check("abort borrow", 32'(if8.borrow), 32'd0);
      check("abort zero", 32'(if8.zero), 32'd0);
      done_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (if8.done) done_cnt++;
      end
      check("abort no_done", 32'(done_cnt), 32'd0);
      last_diff = 8'h00;
      run_op("9-4", 8'h09, 8'h04, -1, 8'h05, 1'b0, 1'b0);

      // WIDTH=1: every (a,b) pair from varied prior results
      run_op1("w1 0-1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      run_op1("w1 1-0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op1("w1 1-1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      run_op1("w1 0-0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op1("w1 1-1b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      run_op1("w1 0-1b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      run_op1("w1 0-0b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op1("w1 1-0b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
